// File: rtl/ir_pkg.sv
// Shared IR beacon definitions: detector decision codes, scan FSM states, clock rate.
package ir_pkg;
    localparam int CLK_HZ = 100_000_000;

    typedef enum logic [2:0] {
        IR_NONE  = 3'd0,
        IR_200HZ = 3'd1,
        IR_1KHZ  = 3'd2,
        IR_5KHZ  = 3'd3,
        IR_7KHZ  = 3'd4
    } ir_code_e;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DISCARD,
        MEASURE,
        REPORT
    } scan_state_e;
endpackage

// File: rtl/ir_confirm_filter.sv
// Run-length filter: confirms once CONFIRM_COUNT consecutive samples carry the same decision.
module ir_confirm_filter
    import ir_pkg::*;
#(
    parameter int CONFIRM_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [2:0] sample,
    input  logic       clear,
    output logic       confirmed,
    output logic [2:0] code
);
    localparam int CW = $clog2(CONFIRM_COUNT) + 1;

    logic [2:0]    last;
    logic [CW-1:0] match_cnt;
    logic [CW-1:0] next_cnt;

    // Confirmation is decided combinationally so the controller can act on the same sample.
    always_comb begin
        next_cnt = CW'(1);
        if (match_cnt != '0 && sample == last) begin
            if (match_cnt == {CW{1'b1}}) next_cnt = match_cnt;
            else                         next_cnt = match_cnt + CW'(1);
        end
    end

    assign confirmed = sample_valid && (next_cnt == CW'(CONFIRM_COUNT));
    assign code      = sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= '0;
            match_cnt <= '0;
        end else if (clear) begin
            match_cnt <= '0;
        end else if (sample_valid) begin
            last      <= sample;
            match_cnt <= next_cnt;
        end
    end
endmodule

// File: rtl/ir_scan_controller.sv
// Scans the IR sensors through one shared detector: settle, discard first period,
// confirm a stable decision (or time out) and record one 3-bit code per sensor.
module ir_scan_controller
    import ir_pkg::*;
#(
    parameter int NUM_SENSORS    = 3,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int CONFIRM_COUNT  = 3,
    parameter int TIMEOUT_CYCLES = 3_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     det_done,
    input  logic [2:0]               det_decision,
    output logic [1:0]               sensor_sel,
    output logic                     result_valid,
    output logic [1:0]               result_sensor,
    output logic [3*NUM_SENSORS-1:0] scan_codes,
    output logic                     sweep_done
);
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    scan_state_e   state;
    logic          done_d;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          sample_valid;
    logic          confirmed;
    logic          timeout_hit;
    logic          last_sensor;
    logic          report_go;
    logic [2:0]    filt_code;
    logic [2:0]    report_code;

    assign sample_valid = done_d && (state == MEASURE);
    assign timeout_hit  = timeout_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign last_sensor  = sensor_sel == 2'(NUM_SENSORS - 1);

    ir_confirm_filter #(
        .CONFIRM_COUNT(CONFIRM_COUNT)
    ) u_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .sample      (det_decision),
        .clear       (state != MEASURE),
        .confirmed   (confirmed),
        .code        (filt_code)
    );

    // Confirmation outranks a coincident timeout; a dropped enable outranks both.
    always_comb begin
        report_go   = 1'b0;
        report_code = IR_NONE;
        if (enable) begin
            if (state == MEASURE && confirmed) begin
                report_go   = 1'b1;
                report_code = filt_code;
            end else if ((state == DISCARD || state == MEASURE) && timeout_hit) begin
                report_go = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            done_d        <= 1'b0;
            settle_cnt    <= '0;
            timeout_cnt   <= '0;
            sensor_sel    <= '0;
            scan_codes    <= '0;
            result_valid  <= 1'b0;
            result_sensor <= '0;
            sweep_done    <= 1'b0;
        end else begin
            done_d       <= det_done;
            result_valid <= 1'b0;
            sweep_done   <= 1'b0;
            if (report_go) begin
                state         <= REPORT;
                result_valid  <= 1'b1;
                result_sensor <= sensor_sel;
                sweep_done    <= last_sensor;
                for (int i = 0; i < NUM_SENSORS; i++)
                    if (sensor_sel == 2'(i)) scan_codes[3*i +: 3] <= report_code;
            end else begin
                case (state)
                    IDLE: begin
                        sensor_sel <= '0;
                        if (enable) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                    SETTLE: begin
                        if (!enable) begin
                            state      <= IDLE;
                            sensor_sel <= '0;
                        end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                            state       <= DISCARD;
                            timeout_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                    DISCARD, MEASURE: begin
                        if (!enable) begin
                            state      <= IDLE;
                            sensor_sel <= '0;
                        end else begin
                            // Never reaches past TIMEOUT_CYCLES-1: the hit reports first.
                            timeout_cnt <= timeout_cnt + TW'(1);
                            if (state == DISCARD && done_d) state <= MEASURE;
                        end
                    end
                    REPORT: begin
                        sensor_sel <= (last_sensor || !enable) ? 2'd0 : sensor_sel + 2'd1;
                        settle_cnt <= '0;
                        state      <= enable ? SETTLE : IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ir_scan_controller.sv
// Scoreboard bench: a phase-locked detector model drives decisions per sensor, expected
// results (sensor, code, sweep flag, cycle of arrival within the sensor phase) are queued.
module tb_ir_scan_controller;
    localparam int NS  = 3;
    localparam int SET = 20;
    localparam int CNF = 3;
    localparam int TMO = 400;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            det_done = 1'b0;
    logic [2:0]      det_decision = 3'd0;
    logic [1:0]      sensor_sel;
    logic            result_valid;
    logic [1:0]      result_sensor;
    logic [3*NS-1:0] scan_codes;
    logic            sweep_done;

    ir_scan_controller #(
        .NUM_SENSORS   (NS),
        .SETTLE_CYCLES (SET),
        .CONFIRM_COUNT (CNF),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .det_done     (det_done),
        .det_decision (det_decision),
        .sensor_sel   (sensor_sel),
        .result_valid (result_valid),
        .result_sensor(result_sensor),
        .scan_codes   (scan_codes),
        .sweep_done   (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sensor;
        int code;
        int sweep;
        int lat;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    int              checks = 0;
    int              failures = 0;
    int              first_c[NS];
    int              per_c[NS];
    int              seq_c[NS][5];
    int              ph = 0;
    int              np = 0;
    int              start_req = 0;
    int              start_ack = 0;
    logic            rv_prev = 1'b0;
    logic [3*NS-1:0] model_codes = '0;

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(int s, int f, int p, int d0, int d1, int d2, int d3, int d4);
        first_c[s]  = f;
        per_c[s]    = p;
        seq_c[s][0] = d0;
        seq_c[s][1] = d1;
        seq_c[s][2] = d2;
        seq_c[s][3] = d3;
        seq_c[s][4] = d4;
    endtask

    task automatic push(int s, int c, int sw, int lat);
        exp_t x;
        x.sensor = s;
        x.code   = c;
        x.sweep  = sw;
        x.lat    = lat;
        sb.push_back(x);
    endtask

    task automatic start_scan();
        @(negedge clk);
        enable = 1'b1;
        start_req++;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic wait_phase(int s, int p, int budget);
        int n  = 0;
        int ok = 0;
        while (n < budget && ok == 0) begin
            @(negedge clk);
            n++;
            if (sensor_sel == 2'(s) && ph >= p) ok = 1;
        end
        chk("wait_phase", ok, 1);
    endtask

    // Detector model: phase 0 is the first SETTLE cycle of each sensor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start_ack != start_req || rv_prev) begin
                ph = 0;
                np = 0;
                start_ack = start_req;
            end else begin
                ph++;
            end
            rv_prev = result_valid;
            if (det_done) begin
                det_decision = 3'(seq_c[sensor_sel][(np < 5) ? np : 4]);
                np++;
            end
            det_done = 1'b0;
            if (per_c[sensor_sel] != 0 && ph >= first_c[sensor_sel])
                if ((ph - first_c[sensor_sel]) % per_c[sensor_sel] == 0) det_done = 1'b1;
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_codes = '0;
            end else if (result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexp_result", result_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("res_sensor", result_sensor, e.sensor);
                    chk("res_code", scan_codes[3*e.sensor +: 3], e.code);
                    chk("sweep_done", sweep_done, e.sweep);
                    chk("latency", ph, e.lat);
                    model_codes[3*e.sensor +: 3] = 3'(e.code);
                    chk("scan_codes", scan_codes, model_codes);
                end
            end else if (sweep_done) begin
                chk("sweep_orphan", sweep_done, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < NS; s++) set_cfg(s, 22, 30, 2, 2, 2, 2, 2);
        repeat (3) @(negedge clk);
        chk("rst_sel", sensor_sel, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_rs", result_sensor, 0);
        chk("rst_sweep", sweep_done, 0);
        chk("rst_codes", scan_codes, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_sel", sensor_sel, 0);
        chk("idle_rv", result_valid, 0);

        // Sweep 1: 1 kHz everywhere, discard + 3 confirmations
        push(0, 2, 0, 114);
        push(1, 2, 0, 114);
        push(2, 2, 1, 114);
        start_scan();
        drain(3000);

        // Sweep 2: code 7, run broken by 2 then 3,3,3, silent sensor times out
        set_cfg(0, 22, 30, 7, 7, 7, 7, 7);
        set_cfg(1, 22, 30, 1, 2, 3, 3, 3);
        set_cfg(2, 0, 0, 0, 0, 0, 0, 0);
        push(0, 7, 0, 114);
        push(1, 3, 0, 144);
        push(2, 0, 1, SET + TMO);
        drain(3000);

        // Sweep 3: sensor 1 confirms on the exact timeout cycle
        set_cfg(0, 22, 30, 5, 5, 5, 5, 5);
        set_cfg(1, 22, 132, 6, 6, 6, 6, 6);
        set_cfg(2, 22, 30, 1, 1, 1, 1, 1);
        push(0, 5, 0, 114);
        push(1, 6, 0, SET + TMO);
        push(2, 1, 1, 114);
        drain(3000);

        // Sweep 4: drop enable mid-MEASURE of sensor 1
        set_cfg(0, 22, 30, 3, 3, 3, 3, 3);
        set_cfg(1, 22, 30, 2, 2, 2, 2, 2);
        push(0, 3, 0, 114);
        drain(3000);
        wait_phase(1, 100, 1000);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_sel", sensor_sel, 0);
        repeat (200) @(negedge clk);
        chk("abort_sel_hold", sensor_sel, 0);
        chk("abort_codes", scan_codes, model_codes);

        // Re-enable restarts at sensor 0, then reset mid-MEASURE of sensor 1
        set_cfg(0, 22, 30, 1, 1, 1, 1, 1);
        push(0, 1, 0, 114);
        start_scan();
        drain(3000);
        wait_phase(1, 60, 1000);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("mrst_sel", sensor_sel, 0);
        chk("mrst_rv", result_valid, 0);
        chk("mrst_rs", result_sensor, 0);
        chk("mrst_sweep", sweep_done, 0);
        chk("mrst_codes", scan_codes, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_sel", sensor_sel, 0);
        chk("post_rst_codes", scan_codes, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
